cover_toggle_sched: RTL and testbench
=====================================

# cover_toggle_sched

Coverage-event scheduler between toggle-cover sampling points and the single coverage-reporting port. Accepts per-cycle valid vectors from NUM_REQ requesters (each VEC_W toggle points with a static base cover index), holds unreported hits in per-requester pending registers, and serialises them one cover index per cycle through a valid/ready output. Round-robin across requesters, lowest-bit-first within a requester. Indices at or above COVER_TOTAL are counted as errors, never emitted.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- VEC_W, 4, toggle points per requester (1..32)
- IDX_W, 64, cover index width
- COVER_TOTAL, 28338, number of valid cover indices
- CNT_W, 32, statistics counter width
- gbl_clk  in  1  clock
- reset  in  1  synchronous, active-low; reset is applied on gbl_clk edges where reset==0
- enable  in  1  capture enable; 0 = ignore req_valid, keep draining
- req_valid  in  NUM_REQ*VEC_W  hit bits; requester r owns slice [r*VEC_W +: VEC_W]
- req_base  in  NUM_REQ*IDX_W  base index of requester r; static outside reset
- out_valid  out  1  cover event available
- out_index  out  IDX_W  cover index = base + bit position
- out_ready  in  1  consumer accepts event
- busy  out  1  any pending bit or out_valid set
- emit_count  out  CNT_W  accepted events (out_valid && out_ready), saturating
- err_count  out  CNT_W  suppressed out-of-range events, saturating

## Operation
- Per requester r: pending[r] (VEC_W bits). Each cycle: pending[r] <= (pending[r] & ~clr[r]) | (enable ? req_valid_r : 0). Set wins over clear on the same bit (re-hit during service is reported again).
- Arbiter picks requester g = first r with pending[r]!=0 searching from rr_ptr upward (wrap), bit b = lowest set bit of pending[g]. Pick occurs only when the output stage is loadable: !out_valid || out_ready.
- On pick: clr[g][b]=1; idx = req_base[g] + b (IDX_W add, no wrap expected). If idx < COVER_TOTAL: out_index<=idx, out_valid<=1. Else: out_valid not loaded this cycle, err_count++.
- rr_ptr advances to g+1 (mod NUM_REQ) only when pending[g] becomes zero after the clear; a requester with multiple bits is drained before the pointer moves.
- FSM (cover_sched_pkg::state_t): IDLE (no pending, out empty) -> SERVE when any pending bit. SERVE -> DRAIN when no pending but out_valid held. DRAIN -> IDLE on out_ready; DRAIN -> SERVE on new pending. SERVE -> IDLE when last pick is an error and nothing remains.
- out_valid/out_index stable while out_valid && !out_ready. No events dropped; backpressure holds bits in pending.
- Counters saturate at 2^CNT_W-1.
- Reset: pending=0, rr_ptr=0, state=IDLE, out_valid=0, out_index=0, emit_count=0, err_count=0, busy=0. Reset mid-operation discards pending and any held output event.

## Timing
- req_valid sampled cycle t -> pending at t+1 -> out_valid at t+2 (uncontended, out_ready=1).
- Throughput: one event per cycle with out_ready held high.
- busy = |pending || out_valid, combinational from registers.
- enable falling: hits on that cycle ignored; already-pending bits still emitted.
- Worst-case drain of a full bank: NUM_REQ*VEC_W accepted cycles.

## Structure
- cover_sched_pkg: state_t enum (IDLE, SERVE, DRAIN), default COVER_TOTAL, IDX_W, CNT_W localparams, sat_inc function.
- Sub-module rr_arbiter: NUM_REQ-wide request vector + pointer in, one-hot grant + index out, purely combinational; priority encoder for lowest-bit inline.
- Top: pending bank, output register, FSM, counters.

## Test plan
- Single hit: req 0 base 100, req_valid[2]=1 one cycle, out_ready=1 -> out_index=102 at t+2, emit_count=1, busy low at t+3.
- Round-robin: req 0 bits 0b0011 (base 0), req 1 bit 0b0001 (base 10) same cycle -> outputs 0,1,10 on consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles with 3 pending -> out_index held stable, no loss; out_ready=1 -> remaining 3 drained, emit_count=3.
- Out of range: base 28336, req_valid=0b1111 -> emits 28336, 28337; err_count=2; FSM returns IDLE.
- Re-hit and enable: bit re-asserted on its clear cycle -> reported twice; enable=0 with req_valid=all ones -> no pending, no output.
- Reset mid-drain: 8 pending, assert reset=0 one cycle -> out_valid=0, busy=0, counters 0, no further events.

Source files
------------

// File: rtl/cover_toggle_sched_pkg.sv
// Shared types and defaults for the toggle-cover event scheduler.
// Holds the FSM encoding and the saturating counter helper.
package cover_sched_pkg;

   localparam int DEF_IDX_W       = 64;
   localparam int DEF_COVER_TOTAL = 28338;
   localparam int DEF_CNT_W       = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Increment that sticks at the all-ones value of a w-bit counter (w <= 64).
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
      logic [63:0] max;
      max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (v >= max) ? v : v + 64'd1;
   endfunction

endpackage

// File: rtl/cover_toggle_sched_if.sv
// Requester/consumer bundle of the cover scheduler; slave is the scheduler side.
interface cover_toggle_sched_if
   import cover_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int VEC_W   = 4,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int CNT_W   = DEF_CNT_W
);
   logic                       enable;
   logic [NUM_REQ*VEC_W-1:0]   req_valid;
   logic [NUM_REQ*IDX_W-1:0]   req_base;
   logic                       out_valid;
   logic [IDX_W-1:0]           out_index;
   logic                       out_ready;
   logic                       busy;
   logic [CNT_W-1:0]           emit_count;
   logic [CNT_W-1:0]           err_count;

   modport master (
      output enable, req_valid, req_base, out_ready,
      input  out_valid, out_index, busy, emit_count, err_count
   );

   modport slave (
      input  enable, req_valid, req_base, out_ready,
      output out_valid, out_index, busy, emit_count, err_count
   );
endinterface

// File: rtl/cover_toggle_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above the pointer, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [PTR_W-1:0]   o_gnt_idx,
   output logic               o_any
);

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_any     = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!o_any && i_req[PTR_W'((int'(i_ptr) + i) % NUM_REQ)]) begin
            o_any = 1'b1;
            o_gnt[PTR_W'((int'(i_ptr) + i) % NUM_REQ)] = 1'b1;
            o_gnt_idx = PTR_W'((int'(i_ptr) + i) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/cover_toggle_sched.sv
// Serialises per-requester toggle hits into one cover index per cycle.
// Round-robin across requesters, lowest bit first; out-of-range indices are only counted.
module cover_toggle_sched
   import cover_sched_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int VEC_W       = 4,
   parameter int IDX_W       = DEF_IDX_W,
   parameter int COVER_TOTAL = DEF_COVER_TOTAL,
   parameter int CNT_W       = DEF_CNT_W
)(
   input logic                 gbl_clk,
   input logic                 reset,
   cover_toggle_sched_if.slave bus
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int BIT_W = (VEC_W > 1) ? $clog2(VEC_W) : 1;

   logic [NUM_REQ-1:0][VEC_W-1:0] r_pend, w_pend_nxt, w_set, w_clr;
   logic [NUM_REQ-1:0]            w_req_any, w_gnt;
   logic [PTR_W-1:0]              r_ptr, w_gidx;
   logic                          w_any, w_load, w_pick, w_in_range, w_last, w_ov_nxt;
   logic [VEC_W-1:0]              w_gvec, w_bit_oh;
   logic [BIT_W-1:0]              w_bit;
   logic [IDX_W-1:0]              w_idx, r_out_index;
   logic                          r_out_valid;
   logic [CNT_W-1:0]              r_emit, r_err;
   state_t                        r_state, w_state_nxt;

   genvar gr;
   generate
      for (gr = 0; gr < NUM_REQ; gr++) begin : g_req
         assign w_req_any[gr] = |r_pend[gr];
         assign w_set[gr]     = bus.enable ? bus.req_valid[gr*VEC_W +: VEC_W] : '0;
         assign w_clr[gr]     = (w_pick && w_gnt[gr]) ? w_bit_oh : '0;
      end
   endgenerate

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
      .i_req     (w_req_any),
      .i_ptr     (r_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gidx),
      .o_any     (w_any)
   );

   always_comb begin
      w_gvec = r_pend[w_gidx];
      w_bit  = '0;
      for (int b = VEC_W - 1; b >= 0; b--) begin
         if (w_gvec[b]) w_bit = BIT_W'(b);
      end
      w_bit_oh   = VEC_W'(1) << w_bit;
      w_idx      = bus.req_base[w_gidx*IDX_W +: IDX_W] + IDX_W'(w_bit);
      w_in_range = w_idx < IDX_W'(COVER_TOTAL);
      w_last     = (w_gvec & ~w_bit_oh) == '0;
      w_load     = !r_out_valid || bus.out_ready;
      w_pick     = w_load && w_any;
      // A re-hit landing on the clear cycle survives, so it is reported again.
      w_pend_nxt = (r_pend & ~w_clr) | w_set;
      w_ov_nxt   = (w_pick && w_in_range) || (r_out_valid && !bus.out_ready);
   end

   always_ff @(posedge gbl_clk) begin
      if (!reset) begin
         r_pend      <= '0;
         r_ptr       <= '0;
         r_out_valid <= 1'b0;
         r_out_index <= '0;
         r_emit      <= '0;
         r_err       <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         // Pointer only moves once the granted requester is fully drained.
         if (w_pick && w_last)
            r_ptr <= (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
         if (w_pick && w_in_range) begin
            r_out_valid <= 1'b1;
            r_out_index <= w_idx;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (r_out_valid && bus.out_ready)
            r_emit <= CNT_W'(sat_inc(64'(r_emit), CNT_W));
         if (w_pick && !w_in_range)
            r_err <= CNT_W'(sat_inc(64'(r_err), CNT_W));
      end
   end

   always_ff @(posedge gbl_clk) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (|w_pend_nxt) w_state_nxt = SERVE;
         SERVE:   if (!(|w_pend_nxt)) w_state_nxt = w_ov_nxt ? DRAIN : IDLE;
         DRAIN: begin
            if (|w_pend_nxt)   w_state_nxt = SERVE;
            else if (!w_ov_nxt) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.out_valid  = r_out_valid;
   assign bus.out_index  = r_out_index;
   assign bus.busy       = (|r_pend) || r_out_valid;
   assign bus.emit_count = r_emit;
   assign bus.err_count  = r_err;

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Scoreboarded bench for cover_toggle_sched: expected indices queued at stimulus time.
module tb_cover_toggle_sched;

   logic gbl_clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;
   logic [63:0] sb[$];

   always #5 gbl_clk = ~gbl_clk;

   cover_toggle_sched_if bus ();

   cover_toggle_sched u_dut (
      .gbl_clk (gbl_clk),
      .reset   (reset),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Accepted events are popped and compared in order.
   always @(negedge gbl_clk) begin
      if (reset && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) chk("sb_unexpected", 64'(sb.size()), 64'd1);
         else chk("sb_index", bus.out_index, sb.pop_front());
      end
   end

   task automatic cyc();
      @(posedge gbl_clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      sb.delete();
   endtask

   task automatic set_base(input int r, input logic [63:0] v);
      bus.req_base[r*64 +: 64] = v;
   endtask

   task automatic hit(input logic [15:0] v);
      bus.req_valid = v;
      cyc();
      bus.req_valid = '0;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((bus.busy || bus.out_valid) && n < 200) begin
         cyc();
         n++;
      end
      if (n >= 200) chk({tag, "_timeout"}, 64'(n), 64'd0);
      cyc();
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      reset         = 1'b0;
      bus.enable    = 1'b1;
      bus.out_ready = 1'b1;
      bus.req_valid = '0;
      bus.req_base  = '0;
      repeat (2) cyc();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy",      64'(bus.busy), 64'd0);
      chk("rst_emit",      64'(bus.emit_count), 64'd0);
      chk("rst_err",       64'(bus.err_count), 64'd0);
      reset = 1'b1;

      // Single hit: latency and completion
      do_reset();
      set_base(0, 64'd100);
      sb.push_back(64'd102);
      hit(16'h0004);
      chk("single_lat1_valid", 64'(bus.out_valid), 64'd0);
      chk("single_lat1_busy",  64'(bus.busy), 64'd1);
      cyc();
      chk("single_lat2_valid", 64'(bus.out_valid), 64'd1);
      chk("single_lat2_index", bus.out_index, 64'd102);
      cyc();
      chk("single_busy_low", 64'(bus.busy), 64'd0);
      chk("single_emit",     64'(bus.emit_count), 64'd1);

      // Round-robin with a multi-bit requester drained first
      do_reset();
      for (int r = 0; r < 4; r++) set_base(r, 64'(r * 10));
      sb.push_back(64'd0); sb.push_back(64'd1); sb.push_back(64'd10);
      hit(16'h0013);
      cyc();
      chk("rr_first", bus.out_index, 64'd0);
      cyc();
      chk("rr_second", bus.out_index, 64'd1);
      cyc();
      chk("rr_third", bus.out_index, 64'd10);
      wait_drain("rr");
      chk("rr_emit", 64'(bus.emit_count), 64'd3);

      // Backpressure holds the output stable and loses nothing
      do_reset();
      set_base(0, 64'd0);
      bus.out_ready = 1'b0;
      sb.push_back(64'd0); sb.push_back(64'd1); sb.push_back(64'd2);
      hit(16'h0007);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("bp_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_index", bus.out_index, 64'd0);
      end
      chk("bp_emit_held", 64'(bus.emit_count), 64'd0);
      bus.out_ready = 1'b1;
      wait_drain("bp");
      chk("bp_emit", 64'(bus.emit_count), 64'd3);
      chk("bp_err",  64'(bus.err_count), 64'd0);

      // Top of the cover range: two emitted, two suppressed
      do_reset();
      set_base(0, 64'd28336);
      sb.push_back(64'd28336); sb.push_back(64'd28337);
      hit(16'h000F);
      wait_drain("oor");
      chk("oor_emit", 64'(bus.emit_count), 64'd2);
      chk("oor_err",  64'(bus.err_count), 64'd2);
      chk("oor_busy", 64'(bus.busy), 64'd0);

      // Re-hit on the clear cycle is reported again
      do_reset();
      set_base(0, 64'd0);
      sb.push_back(64'd0); sb.push_back(64'd0);
      bus.req_valid = 16'h0001;
      cyc();
      cyc();
      bus.req_valid = '0;
      wait_drain("rehit");
      chk("rehit_emit", 64'(bus.emit_count), 64'd2);

      // Capture disabled: hits ignored
      bus.enable = 1'b0;
      hit(16'hFFFF);
      repeat (3) begin
         cyc();
         chk("en0_busy", 64'(bus.busy), 64'd0);
      end
      chk("en0_emit", 64'(bus.emit_count), 64'd2);
      bus.enable = 1'b1;

      // Reset mid-drain discards everything
      do_reset();
      for (int r = 0; r < 4; r++) set_base(r, 64'(r * 10));
      bus.out_ready = 1'b0;
      hit(16'h0F0F);
      repeat (2) cyc();
      chk("mid_busy_pre",  64'(bus.busy), 64'd1);
      chk("mid_valid_pre", 64'(bus.out_valid), 64'd1);
      do_reset();
      chk("mid_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_busy",  64'(bus.busy), 64'd0);
      chk("mid_emit",  64'(bus.emit_count), 64'd0);
      chk("mid_err",   64'(bus.err_count), 64'd0);
      bus.out_ready = 1'b1;
      repeat (20) cyc();
      chk("mid_after_busy", 64'(bus.busy), 64'd0);
      chk("mid_after_emit", 64'(bus.emit_count), 64'd0);

      chk("sb_final", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
